accel_sequencer: RTL and testbench
==================================

ACCEL_SEQUENCER -- requirements
Module: accel_sequencer

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
- DATASIZE, 8, element width in bits.
- ARRAYWIDTH, 16, elements per tile row.
- LOAD_CYCLES, 16, rows per tile load phase.
- COMPUTE_CYCLES, 65, matmul warm-up cycles before output capture.
- COLLECT_CYCLES, 76, output-buffer capture cycles.
- UNLOAD_CYCLES, 16, output-buffer readout cycles.
REQ-002 Ports SHALL be, one per line: name, direction, width, meaning.
- clk, in, 1, sole clock, rising edge.
- rst, in, 1, asynchronous active-low reset.
- start, in, 1, request one layer run; sampled only in IDLE.
- stat_tile_data, in, DATASIZE*ARRAYWIDTH, stationary-operand row from the input tiler.
- strm_tile_data, in, DATASIZE*ARRAYWIDTH, streamed-operand row from the weight tiler.
- stat_tile_en, out, 1, enable to the stationary tiler (io_enable).
- strm_tile_en, out, 1, enable to the streamed tiler (io_enable).
- in_weight, out, DATASIZE*ARRAYWIDTH, registered stationary row to the accelerator.
- in_act, out, DATASIZE*ARRAYWIDTH, registered streamed row to the accelerator.
- weight_buffer_load_en, out, 1, accelerator weight-buffer write.
- weight_buffer_out_en, out, 1, accelerator weight-buffer read.
- write_weight_en, out, 1, array stationary-register write.
- input_buffer_load_en, out, 1, accelerator input-buffer write.
- input_buffer_out_en, out, 1, accelerator input-buffer read (matmul run).
- output_buffer_load_en, out, 1, output-buffer capture.
- output_buffer_out_en, out, 1, output-buffer readout.
- busy, out, 1, high in every state except IDLE.
- done, out, 1, one-cycle pulse at run end.

Function
REQ-003 FSM states SHALL be IDLE, LOAD_STAT, LOAD_STRM, COMPUTE, COLLECT, UNLOAD, DONE; one phase counter, 8 bits, cleared on every state entry.
REQ-004 IDLE with start=1 at an edge SHALL enter LOAD_STAT next cycle; start in any other state SHALL be ignored, with no queuing.
REQ-005 LOAD_STAT and LOAD_STRM SHALL each last LOAD_CYCLES cycles, COMPUTE COMPUTE_CYCLES, COLLECT COLLECT_CYCLES, UNLOAD UNLOAD_CYCLES, and DONE 1 cycle, then return to IDLE.
REQ-006 Combinational state decodes:
- stat_tile_en = LOAD_STAT.
- strm_tile_en = LOAD_STRM.
- matmul phase = COMPUTE or COLLECT.
- output_buffer_load_en = COLLECT.
- output_buffer_out_en = UNLOAD.
- busy = not IDLE.
- done = DONE.
REQ-007 Registered outputs (1-cycle latency after the decode):
- weight_buffer_load_en <= stat_tile_en.
- input_buffer_load_en, write_weight_en, weight_buffer_out_en <= strm_tile_en.
- input_buffer_out_en <= matmul phase.
REQ-008 in_weight SHALL register stat_tile_data when stat_tile_en=1, else zero; in_act SHALL register strm_tile_data when strm_tile_en=1, else zero; both update in the same cycle as their load enables.
REQ-009 No two of stat_tile_en, strm_tile_en, output_buffer_load_en, output_buffer_out_en SHALL be high simultaneously.
REQ-010 A full run from the start-sampling edge to the done pulse SHALL be 4+2*LOAD_CYCLES+COMPUTE_CYCLES+COLLECT_CYCLES+UNLOAD_CYCLES-3 edges, i.e. the done pulse falls in cycle 190 after start at defaults (start cycle = 0).

Reset
REQ-011 rst=0 SHALL immediately force IDLE, counter 0, every output 0 and data outputs all-zero, including mid-run; operation resumes only on a new start after rst=1.

Structure
REQ-012 DATASIZE, ARRAYWIDTH, the four cycle-count defaults and the state encoding SHALL reside in the shared config package/header.
REQ-013 The block SHALL be a single module with no sub-modules; the tilers and the accelerator are instantiated beside it by the parent.

Verification
REQ-014 Bench SHALL cover:
- Single run, start pulse at cycle 0 -> stat_tile_en high cycles 1-16, strm_tile_en 17-32, output_buffer_load_en 98-173, output_buffer_out_en 174-189, done at 190.
- stat_tile_data = row index -> in_weight rows 0..15 appear in cycles 2-17 alongside weight_buffer_load_en, then zeros.
- start held high continuously -> runs back-to-back, each separated by exactly one IDLE cycle, no overlap.
- rst asserted at cycle 50 (COMPUTE) -> all outputs 0 within the same cycle; start at cycle 60 -> full run timing restarts from cycle 60.
- start pulse during COLLECT -> ignored; exactly one done pulse.
- COMPUTE_CYCLES=1, LOAD_CYCLES=1 override -> phase lengths honoured, mutual exclusion of REQ-009 holds.

Source files
------------

// File: rtl/accel_sequencer_pkg.sv
// Shared configuration for the accelerator sequencer: datapath geometry,
// default phase lengths and the FSM state encoding.
package accel_sequencer_pkg;

   localparam int DATASIZE       = 8;
   localparam int ARRAYWIDTH     = 16;
   localparam int LOAD_CYCLES    = 16;
   localparam int COMPUTE_CYCLES = 65;
   localparam int COLLECT_CYCLES = 76;
   localparam int UNLOAD_CYCLES  = 16;

   localparam logic [2:0] S_IDLE      = 3'd0;
   localparam logic [2:0] S_LOAD_STAT = 3'd1;
   localparam logic [2:0] S_LOAD_STRM = 3'd2;
   localparam logic [2:0] S_COMPUTE   = 3'd3;
   localparam logic [2:0] S_COLLECT   = 3'd4;
   localparam logic [2:0] S_UNLOAD    = 3'd5;
   localparam logic [2:0] S_DONE      = 3'd6;

   // Terminal phase-counter value for a state; single-cycle states end at 0.
   function automatic logic [7:0] phase_last(input logic [2:0] st,
                                             input int load_n,
                                             input int comp_n,
                                             input int coll_n,
                                             input int unld_n);
      int n;
      n = 1;
      case (st)
         S_LOAD_STAT, S_LOAD_STRM: n = load_n;
         S_COMPUTE:                n = comp_n;
         S_COLLECT:                n = coll_n;
         S_UNLOAD:                 n = unld_n;
         default:                  n = 1;
      endcase
      return 8'(n - 1);
   endfunction

endpackage

// File: rtl/accel_sequencer.sv
// Layer-run sequencer: walks tile load, matmul, capture and readout phases and
// drives the tiler enables, accelerator buffer strobes and registered rows.
module accel_sequencer #(
   parameter int DATASIZE       = accel_sequencer_pkg::DATASIZE,
   parameter int ARRAYWIDTH     = accel_sequencer_pkg::ARRAYWIDTH,
   parameter int LOAD_CYCLES    = accel_sequencer_pkg::LOAD_CYCLES,
   parameter int COMPUTE_CYCLES = accel_sequencer_pkg::COMPUTE_CYCLES,
   parameter int COLLECT_CYCLES = accel_sequencer_pkg::COLLECT_CYCLES,
   parameter int UNLOAD_CYCLES  = accel_sequencer_pkg::UNLOAD_CYCLES
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           start,
   input  logic [DATASIZE*ARRAYWIDTH-1:0] stat_tile_data,
   input  logic [DATASIZE*ARRAYWIDTH-1:0] strm_tile_data,
   output logic                           stat_tile_en,
   output logic                           strm_tile_en,
   output logic [DATASIZE*ARRAYWIDTH-1:0] in_weight,
   output logic [DATASIZE*ARRAYWIDTH-1:0] in_act,
   output logic                           weight_buffer_load_en,
   output logic                           weight_buffer_out_en,
   output logic                           write_weight_en,
   output logic                           input_buffer_load_en,
   output logic                           input_buffer_out_en,
   output logic                           output_buffer_load_en,
   output logic                           output_buffer_out_en,
   output logic                           busy,
   output logic                           done
);
   import accel_sequencer_pkg::*;

   localparam int ROW_W = DATASIZE * ARRAYWIDTH;

   logic [2:0]       r_state;
   logic [2:0]       w_next;
   logic [7:0]       r_cnt;
   logic             w_last;
   logic             w_stat_en;
   logic             w_strm_en;
   logic             w_matmul;
   logic             r_wbl;
   logic             r_strm_d;
   logic             r_ibo;
   logic [ROW_W-1:0] r_in_weight;
   logic [ROW_W-1:0] r_in_act;

   assign w_last = (r_cnt == phase_last(r_state, LOAD_CYCLES, COMPUTE_CYCLES,
                                        COLLECT_CYCLES, UNLOAD_CYCLES));

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:      if (start)  w_next = S_LOAD_STAT;
         S_LOAD_STAT: if (w_last) w_next = S_LOAD_STRM;
         S_LOAD_STRM: if (w_last) w_next = S_COMPUTE;
         S_COMPUTE:   if (w_last) w_next = S_COLLECT;
         S_COLLECT:   if (w_last) w_next = S_UNLOAD;
         S_UNLOAD:    if (w_last) w_next = S_DONE;
         S_DONE:                  w_next = S_IDLE;
         default:                 w_next = S_IDLE;
      endcase
   end

   // Counter restarts on every state change and stays parked at 0 in IDLE.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= S_IDLE;
         r_cnt   <= '0;
      end else begin
         r_state <= w_next;
         if (w_next != r_state || r_state == S_IDLE)
            r_cnt <= '0;
         else
            r_cnt <= r_cnt + 8'd1;
      end
   end

   assign w_stat_en = (r_state == S_LOAD_STAT);
   assign w_strm_en = (r_state == S_LOAD_STRM);
   assign w_matmul  = (r_state == S_COMPUTE) || (r_state == S_COLLECT);

   // Accelerator strobes trail the tiler enables by one cycle, matching the
   // tilers' registered row output.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_wbl       <= 1'b0;
         r_strm_d    <= 1'b0;
         r_ibo       <= 1'b0;
         r_in_weight <= '0;
         r_in_act    <= '0;
      end else begin
         r_wbl       <= w_stat_en;
         r_strm_d    <= w_strm_en;
         r_ibo       <= w_matmul;
         r_in_weight <= w_stat_en ? stat_tile_data : '0;
         r_in_act    <= w_strm_en ? strm_tile_data : '0;
      end
   end

   assign stat_tile_en          = w_stat_en;
   assign strm_tile_en          = w_strm_en;
   assign output_buffer_load_en = (r_state == S_COLLECT);
   assign output_buffer_out_en  = (r_state == S_UNLOAD);
   assign busy                  = (r_state != S_IDLE);
   assign done                  = (r_state == S_DONE);

   assign weight_buffer_load_en = r_wbl;
   assign input_buffer_load_en  = r_strm_d;
   assign write_weight_en       = r_strm_d;
   assign weight_buffer_out_en  = r_strm_d;
   assign input_buffer_out_en   = r_ibo;
   assign in_weight             = r_in_weight;
   assign in_act                = r_in_act;

endmodule

// File: tb/tb_accel_sequencer.sv
// Randomized bench for accel_sequencer: a default instance and a short-phase
// instance, both compared every cycle against a run-time-offset model.
module tb_accel_sequencer;

   localparam int W = 128;

   logic         clk = 1'b0;
   logic         rst = 1'b0;
   logic         start = 1'b0;
   logic [W-1:0] sdat = '0;
   logic [W-1:0] tdat = '0;

   logic [1:0]   stat_en, strm_en, wbl, wbo, ww, ibl, ibo, obl, obo, busy, done;
   logic [W-1:0] wgt [2];
   logic [W-1:0] act [2];

   int n_vec = 0;
   int n_err = 0;
   int cyc   = 0;

   // model: t = cycles into the current run (0 = IDLE)
   int           t  [2];
   logic         rs [2];
   logic         rt [2];
   logic         rm [2];
   logic [W-1:0] ew [2];
   logic [W-1:0] ea [2];
   int           LP [2] = '{16, 1};
   int           CP [2] = '{65, 1};

   always #5 clk = ~clk;

   accel_sequencer u_dut (
      .clk(clk), .rst(rst), .start(start),
      .stat_tile_data(sdat), .strm_tile_data(tdat),
      .stat_tile_en(stat_en[0]), .strm_tile_en(strm_en[0]),
      .in_weight(wgt[0]), .in_act(act[0]),
      .weight_buffer_load_en(wbl[0]), .weight_buffer_out_en(wbo[0]),
      .write_weight_en(ww[0]), .input_buffer_load_en(ibl[0]),
      .input_buffer_out_en(ibo[0]), .output_buffer_load_en(obl[0]),
      .output_buffer_out_en(obo[0]), .busy(busy[0]), .done(done[0])
   );

   accel_sequencer #(.LOAD_CYCLES(1), .COMPUTE_CYCLES(1)) u_dut_short (
      .clk(clk), .rst(rst), .start(start),
      .stat_tile_data(sdat), .strm_tile_data(tdat),
      .stat_tile_en(stat_en[1]), .strm_tile_en(strm_en[1]),
      .in_weight(wgt[1]), .in_act(act[1]),
      .weight_buffer_load_en(wbl[1]), .weight_buffer_out_en(wbo[1]),
      .write_weight_en(ww[1]), .input_buffer_load_en(ibl[1]),
      .input_buffer_out_en(ibo[1]), .output_buffer_load_en(obl[1]),
      .output_buffer_out_en(obo[1]), .busy(busy[1]), .done(done[1])
   );

   task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s cyc=%0d: got %0h want %0h", tag, cyc, obs, exp);
      end
   endtask

   function automatic int done_t(input int i);
      return 2 * LP[i] + CP[i] + 76 + 16 + 1;
   endfunction

   // {stat, strm, matmul, collect, unload, busy, done} for run offset tt
   function automatic logic [6:0] dec(input int i, input int tt);
      int L, C;
      L = LP[i];
      C = CP[i];
      return {tt >= 1 && tt <= L,
              tt > L && tt <= 2 * L,
              tt > 2 * L && tt <= 2 * L + C + 76,
              tt > 2 * L + C && tt <= 2 * L + C + 76,
              tt > 2 * L + C + 76 && tt <= 2 * L + C + 92,
              tt != 0,
              tt == done_t(i)};
   endfunction

   function automatic logic [W-1:0] rnd();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   function automatic logic [10:0] obs_ctl(input int i);
      return {stat_en[i], strm_en[i], wbl[i], wbo[i], ww[i], ibl[i], ibo[i],
              obl[i], obo[i], busy[i], done[i]};
   endfunction

   task automatic model_clear();
      for (int i = 0; i < 2; i++) begin
         t[i] = 0; rs[i] = 0; rt[i] = 0; rm[i] = 0; ew[i] = '0; ea[i] = '0;
      end
   endtask

   task automatic model_edge();
      logic [6:0] d;
      if (!rst) begin
         model_clear();
         return;
      end
      for (int i = 0; i < 2; i++) begin
         d = dec(i, t[i]);
         rs[i] = d[6];
         rt[i] = d[5];
         rm[i] = d[4];
         ew[i] = d[6] ? sdat : '0;
         ea[i] = d[5] ? tdat : '0;
         if (t[i] == 0)             t[i] = start ? 1 : 0;
         else if (t[i] == done_t(i)) t[i] = 0;
         else                        t[i] = t[i] + 1;
      end
   endtask

   task automatic check_all();
      logic [6:0]  d;
      logic [10:0] e;
      int          ones;
      for (int i = 0; i < 2; i++) begin
         d = dec(i, t[i]);
         e = {d[6], d[5], rs[i], rt[i], rt[i], rt[i], rm[i], d[3], d[2], d[1], d[0]};
         chk(i == 0 ? "ctl_def" : "ctl_short", obs_ctl(i), e);
         chk(i == 0 ? "wgt_def" : "wgt_short", wgt[i], ew[i]);
         chk(i == 0 ? "act_def" : "act_short", act[i], ea[i]);
         ones = int'(stat_en[i]) + int'(strm_en[i]) + int'(obl[i]) + int'(obo[i]);
         chk(i == 0 ? "excl_def" : "excl_short", ones <= 1, 1'b1);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      model_edge();
      @(negedge clk);
      check_all();
      cyc++;
   endtask

   // stationary data carries the row index while the default instance loads
   task automatic drive(input bit rowmode);
      logic [6:0] d;
      d = dec(0, t[0]);
      sdat = (rowmode && d[6]) ? W'(t[0] - 1) : rnd();
      tdat = rnd();
   endtask

   task automatic async_reset();
      rst = 1'b0;
      #1;
      model_clear();
      check_all();
      chk("rst_ctl", {obs_ctl(0), obs_ctl(1)}, '0);
      chk("rst_data", {wgt[0], act[0]}, '0);
   endtask

   task automatic drain();
      int n;
      start = 1'b0;
      n = 0;
      while ((t[0] != 0 || t[1] != 0) && n < 400) begin
         drive(0);
         tick();
         n++;
      end
      chk("drain_idle", {busy[0], busy[1]}, 2'b00);
   endtask

   int ndone;

   initial begin
      model_clear();
      @(negedge clk);
      async_reset();
      tick();
      tick();
      rst = 1'b1;

      // single run with row-index stationary data
      cyc = 0;
      start = 1'b1;
      drive(1);
      tick();
      start = 1'b0;
      while (cyc <= 195) begin
         case (cyc)
            1:   chk("s1_stat_first", stat_en[0], 1'b1);
            2:   chk("s1_row0", {wbl[0], wgt[0]}, {1'b1, 128'd0});
            9:   chk("s1_row7", {wbl[0], wgt[0]}, {1'b1, 128'd7});
            16:  chk("s1_stat_last", stat_en[0], 1'b1);
            17:  chk("s1_stat2strm", {stat_en[0], strm_en[0], wgt[0]}, {2'b01, 128'd15});
            18:  chk("s1_row_end", {wbl[0], wgt[0]}, {1'b0, 128'd0});
            32:  chk("s1_strm_last", strm_en[0], 1'b1);
            33:  chk("s1_strm_off", strm_en[0], 1'b0);
            97:  chk("s1_obl_pre", obl[0], 1'b0);
            98:  chk("s1_obl_first", obl[0], 1'b1);
            173: chk("s1_obl_last", {obl[0], obo[0]}, 2'b10);
            174: chk("s1_obo_first", {obl[0], obo[0]}, 2'b01);
            189: chk("s1_obo_last", {obo[0], done[0]}, 2'b10);
            190: chk("s1_done", {obo[0], done[0], busy[0]}, 3'b011);
            191: chk("s1_idle", {done[0], busy[0]}, 2'b00);
            default: ;
         endcase
         drive(1);
         tick();
      end
      drain();

      // start held high: back-to-back runs with one IDLE cycle between
      cyc = 0;
      ndone = 0;
      start = 1'b1;
      while (cyc < 600) begin
         drive(0);
         tick();
         if (done[0]) ndone++;
         if (cyc == 191) chk("b2b_gap_idle", busy[0], 1'b0);
         if (cyc == 192) chk("b2b_restart", stat_en[0], 1'b1);
      end
      chk("b2b_dones", ndone, 3);
      drain();

      // reset mid-COMPUTE, then a fresh run at cycle 60
      cyc = 0;
      start = 1'b1;
      drive(0);
      tick();
      start = 1'b0;
      while (cyc < 50) begin drive(0); tick(); end
      chk("c50_compute", {busy[0], ibo[0]}, 2'b11);
      async_reset();
      while (cyc < 55) begin drive(0); tick(); end
      rst = 1'b1;
      while (cyc < 60) begin drive(0); tick(); end
      start = 1'b1;
      drive(0);
      tick();
      start = 1'b0;
      chk("r60_stat", stat_en[0], 1'b1);
      while (cyc < 252) begin
         if (cyc == 249) chk("r60_pre_done", done[0], 1'b0);
         if (cyc == 250) chk("r60_done", done[0], 1'b1);
         drive(0);
         tick();
      end
      drain();

      // start pulse during COLLECT is ignored
      cyc = 0;
      ndone = 0;
      start = 1'b1;
      drive(0);
      tick();
      start = 1'b0;
      while (cyc < 320) begin
         start = (cyc == 120);
         drive(0);
         tick();
         if (done[0]) ndone++;
      end
      chk("collect_start_dones", ndone, 1);
      drain();

      // random traffic with occasional mid-run resets
      for (int k = 0; k < 3000; k++) begin
         if ($urandom_range(0, 199) == 0) begin
            async_reset();
            start = 1'b0;
            drive(0);
            tick();
            rst = 1'b1;
         end
         start = ($urandom_range(0, 9) == 0);
         drive($urandom_range(0, 1) == 1);
         tick();
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
